regfile_2r1w: RTL and testbench
===============================

REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter: DW, default 8, data width in bits (1..32).
REQ-002 Parameter: AW, default 4, address width; DEPTH = 2^AW entries.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 CLB  input  1  reset, synchronous, active-low; sampled only on rising clk.
REQ-005 LoadReg  input  1  write enable.
REQ-006 WrAddr  input  AW  write address.
REQ-007 WrData  input  DW  write data.
REQ-008 RdAddrA  input  AW  read port A address.
REQ-009 RdAddrB  input  AW  read port B address.
REQ-010 ClrReq  input  1  soft-clear request, level-sampled.
REQ-011 RdDataA  output  DW  registered read data, port A.
REQ-012 RdDataB  output  DW  registered read data, port B.
REQ-013 Busy  output  1  registered; high while clear sweep in progress.
REQ-014 WrDrop  output  1  registered one-cycle pulse, write rejected.

Function
REQ-015 Storage SHALL be DEPTH x DW; one write port and two independent read ports.
REQ-016 Controller SHALL have two states: IDLE and CLEAR; clear pointer SHALL be AW bits.
REQ-017 IDLE, LoadReg=1: mem[WrAddr] <= WrData at the edge; WrDrop=0.
REQ-018 Read latency SHALL be one cycle: RdDataX at edge N+1 reflects RdAddrX sampled at edge N.
REQ-019 Write-first bypass: if LoadReg=1 in IDLE and RdAddrX==WrAddr on the same edge, RdDataX SHALL take WrData, not the old entry.
REQ-020 Ports A and B reading the same address SHALL both return identical data; the bypass SHALL apply to each port independently.
REQ-021 IDLE, ClrReq=1: state -> CLEAR, pointer <= 0, Busy <= 1 at that edge; a LoadReg on that same edge SHALL still be performed (write then clear).
REQ-022 CLEAR: each edge writes mem[pointer] <= 0 and increments the pointer; the edge clearing entry DEPTH-1 SHALL set state IDLE and Busy <= 0.
REQ-023 Sweep SHALL take exactly DEPTH cycles; pointer wrap DEPTH-1 -> 0 SHALL coincide with the return to IDLE.
REQ-024 CLEAR, LoadReg=1: write SHALL be discarded and WrDrop <= 1 on that edge; WrDrop <= 0 on any edge without a discarded write.
REQ-025 CLEAR: RdDataA/RdDataB SHALL be loaded with 0 regardless of address.
REQ-026 CLEAR, ClrReq=1: ignored; the sweep SHALL NOT restart.
REQ-027 Last-sweep edge: reads on that edge SHALL return 0; the first IDLE edge SHALL perform normal reads and writes.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 Each edge with CLB=0: state <= CLEAR, pointer <= 0, Busy <= 1, WrDrop <= 0, RdDataA/B <= 0; no memory write.
REQ-030 First edge with CLB=1 SHALL clear entry 0; Busy SHALL fall after DEPTH edges with CLB=1.
REQ-031 CLB=0 mid-sweep or mid-operation SHALL restart the sweep from pointer 0; CLB overrides ClrReq and LoadReg.
REQ-032 Memory contents are unspecified before the first full sweep completes; outputs SHALL never expose them.

Verification
REQ-033 Reset: CLB=0 for 2 edges, then high -> Busy=1 for exactly 16 edges (defaults), RdDataA/B=0 throughout; reads of all 16 addresses afterwards return 0x00.
REQ-034 Write/read: write 0xA5 to 3, then RdAddrA=3, RdAddrB=3 -> both read 0xA5 one cycle later; RdAddrB=4 -> 0x00.
REQ-035 Bypass: LoadReg=1, WrAddr=7, WrData=0x3C, RdAddrA=7, old mem[7]=0x11 -> RdDataA=0x3C next cycle; mem[7]=0x3C afterwards.
REQ-036 Soft clear with write: ClrReq=1 one cycle, LoadReg=1 on the 5th sweep edge -> WrDrop pulse one cycle, write lost, Busy=1 for 16 cycles, all entries 0x00.
REQ-037 Reset mid-sweep: CLB=0 at sweep cycle 9 for 1 edge -> sweep restarts, Busy stays high 16 further edges.
REQ-038 Parameters DW=16, AW=2: write 0xBEEF to 2 -> reads 0xBEEF; reset sweep Busy length = 4 edges.

Source files
------------

// File: rtl/regfile_2r1w.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
//   DEPTH x DW register file with one write port and two independent,
//   registered read ports. A two-state controller (IDLE / CLEAR) zeroes the
//   whole array one entry per cycle after reset or on a soft-clear request.
//   While the sweep runs, reads return zero and writes are rejected with a
//   one-cycle WrDrop pulse.
//
// Parameters
//   DW       data width in bits (1..32)
//   AW       address width; DEPTH = 2**AW entries
//
// Ports
//   clk      sole clock, rising-edge active
//   CLB      synchronous active-low reset (forces a fresh clear sweep)
//   LoadReg  write enable
//   WrAddr   write address
//   WrData   write data
//   RdAddrA  read address, port A
//   RdAddrB  read address, port B
//   ClrReq   soft-clear request, level sampled in IDLE
//   RdDataA  registered read data, port A (one-cycle latency)
//   RdDataB  registered read data, port B (one-cycle latency)
//   Busy     registered, high while the clear sweep is in progress
//   WrDrop   registered one-cycle pulse when a write is discarded
// ----------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          LoadReg,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] WrData,
    input  logic [AW-1:0] RdAddrA,
    input  logic [AW-1:0] RdAddrB,
    input  logic          ClrReq,
    output logic [DW-1:0] RdDataA,
    output logic [DW-1:0] RdDataB,
    output logic          Busy,
    output logic          WrDrop
);

    localparam int unsigned   DEPTH    = 1 << AW;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Controller and output registers
    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q,   ptr_d;
    logic            busy_q,  busy_d;
    logic            drop_q,  drop_d;
    logic [DW-1:0]   rda_q,   rda_d;
    logic [DW-1:0]   rdb_q,   rdb_d;

    // Storage array and its single write port
    logic [DW-1:0]   mem_q [DEPTH];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;

    // Next-state, write-port and read-data selection
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        drop_d    = 1'b0;
        rda_d     = '0;
        rdb_d     = '0;
        mem_we    = 1'b0;
        mem_waddr = WrAddr;
        mem_wdata = WrData;

        case (state_q)
            IDLE: begin
                mem_we = LoadReg;
                busy_d = 1'b0;
                // Write-first: a same-edge write to the read address wins
                rda_d  = (LoadReg && (RdAddrA == WrAddr)) ? WrData : mem_q[RdAddrA];
                rdb_d  = (LoadReg && (RdAddrB == WrAddr)) ? WrData : mem_q[RdAddrB];
                // The write above still lands on the edge that starts the sweep
                if (ClrReq) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            CLEAR: begin
                // Sweep owns the write port; user writes are reported as dropped
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + AW'(1);
                drop_d    = LoadReg;
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Control/output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!CLB) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            drop_q  <= 1'b0;
            rda_q   <= '0;
            rdb_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
        end
    end

    // Array write; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (CLB && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign RdDataA = rda_q;
    assign RdDataB = rdb_q;
    assign Busy    = busy_q;
    assign WrDrop  = drop_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// ----------------------------------------------------------------------------
// tb_regfile_2r1w
//   Two instances: defaults (DW=8, AW=4) and DW=16, AW=2. A reference model
//   per instance keeps the array contents and the number of sweep edges still
//   outstanding; each stimulus edge pushes the expected outputs into a queue
//   and a monitor pops and compares them after every rising edge.
// ----------------------------------------------------------------------------
module tb_regfile_2r1w;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        busy;
        logic        drop;
    } exp_t;

    logic        clk;
    logic        clb  [2];
    logic        ld   [2];
    logic        clr  [2];
    logic [3:0]  wa   [2];
    logic [3:0]  raa  [2];
    logic [3:0]  rab  [2];
    logic [31:0] wd   [2];

    logic [7:0]  rda0, rdb0;
    logic [15:0] rda1, rdb1;
    logic        busy0, busy1, drop0, drop1;

    exp_t        q0 [$];
    exp_t        q1 [$];

    logic [31:0] mmem [2][16];
    int          mdep [2];
    int          rem  [2];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    regfile_2r1w u_dut0 (
        .clk     (clk),
        .CLB     (clb[0]),
        .LoadReg (ld[0]),
        .WrAddr  (wa[0]),
        .WrData  (wd[0][7:0]),
        .RdAddrA (raa[0]),
        .RdAddrB (rab[0]),
        .ClrReq  (clr[0]),
        .RdDataA (rda0),
        .RdDataB (rdb0),
        .Busy    (busy0),
        .WrDrop  (drop0)
    );

    regfile_2r1w #(.DW(16), .AW(2)) u_dut1 (
        .clk     (clk),
        .CLB     (clb[1]),
        .LoadReg (ld[1]),
        .WrAddr  (wa[1][1:0]),
        .WrData  (wd[1][15:0]),
        .RdAddrA (raa[1][1:0]),
        .RdAddrB (rab[1][1:0]),
        .ClrReq  (clr[1]),
        .RdDataA (rda1),
        .RdDataB (rdb1),
        .Busy    (busy1),
        .WrDrop  (drop1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: reset arms a full sweep; each sweep edge zeroes the next
    // entry in ascending order; otherwise write first, then read.
    task automatic model_step(input int k);
        exp_t e;
        e.a    = '0;
        e.b    = '0;
        e.busy = 1'b1;
        e.drop = 1'b0;
        if (!clb[k]) begin
            rem[k] = mdep[k];
        end else if (rem[k] > 0) begin
            mmem[k][mdep[k] - rem[k]] = '0;
            rem[k] = rem[k] - 1;
            e.busy = (rem[k] > 0);
            e.drop = ld[k];
        end else begin
            if (ld[k]) mmem[k][wa[k]] = wd[k];
            e.a    = mmem[k][raa[k]];
            e.b    = mmem[k][rab[k]];
            e.busy = clr[k];
            if (clr[k]) rem[k] = mdep[k];
        end
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Record expectations for the coming edge, then move to the next falling edge
    task automatic tick();
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        clb[k] = 1'b1;
        ld[k]  = 1'b0;
        clr[k] = 1'b0;
    endtask

    task automatic rand_in(input int k);
        int unsigned d;
        d      = unsigned'(mdep[k]);
        clb[k] = ($urandom_range(0, 99) != 0);
        clr[k] = ($urandom_range(0, 39) == 0);
        ld[k]  = ($urandom_range(0, 1) != 0);
        wa[k]  = 4'($urandom_range(0, d - 1));
        raa[k] = ($urandom_range(0, 3) == 0) ? wa[k] : 4'($urandom_range(0, d - 1));
        rab[k] = ($urandom_range(0, 3) == 0) ? wa[k] : 4'($urandom_range(0, d - 1));
        wd[k]  = (k == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 65535));
    endtask

    task automatic cmp(input int k, input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL inst%0d %s cycle %0d: got %h expected %h", k, nm, cyc, got, exp);
        end
    endtask

    // Monitor: outputs are presented every edge; compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                cmp(0, "RdDataA", 32'(rda0),  e.a);
                cmp(0, "RdDataB", 32'(rdb0),  e.b);
                cmp(0, "Busy",    32'(busy0), 32'(e.busy));
                cmp(0, "WrDrop",  32'(drop0), 32'(e.drop));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp(1, "RdDataA", 32'(rda1),  e.a);
                cmp(1, "RdDataB", 32'(rdb1),  e.b);
                cmp(1, "Busy",    32'(busy1), 32'(e.busy));
                cmp(1, "WrDrop",  32'(drop1), 32'(e.drop));
            end
        end
    end

    initial begin
        mdep[0] = 16;
        mdep[1] = 4;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0;
            for (int i = 0; i < 16; i++) mmem[k][i] = 'x;
            clb[k] = 1'b0;
            ld[k]  = 1'b0;
            clr[k] = 1'b0;
            wa[k]  = '0;
            raa[k] = '0;
            rab[k] = '0;
            wd[k]  = '0;
        end

        // Reset for two edges, then the power-up sweep
        tick();
        tick();
        clb[0] = 1'b1;
        clb[1] = 1'b1;
        for (int i = 0; i < 18; i++) begin
            raa[0] = 4'($urandom_range(0, 15));
            rab[0] = 4'($urandom_range(0, 15));
            ld[0]  = (i == 3);
            wa[0]  = 4'd5;
            wd[0]  = 32'h77;
            ld[1]  = (i == 5);
            wa[1]  = 4'd2;
            wd[1]  = 32'hBEEF;
            raa[1] = (i >= 6) ? 4'd2 : 4'($urandom_range(0, 3));
            rab[1] = (i >= 6) ? 4'd2 : 4'($urandom_range(0, 3));
            tick();
        end
        idle(1);

        // All entries read back zero after the sweep
        for (int i = 0; i < 16; i++) begin
            raa[0] = 4'(i);
            rab[0] = 4'(15 - i);
            tick();
        end

        // Plain write then read on both ports, plus an untouched neighbour
        ld[0] = 1'b1; wa[0] = 4'd3; wd[0] = 32'hA5; tick();
        ld[0] = 1'b0; raa[0] = 4'd3; rab[0] = 4'd3; tick();
        rab[0] = 4'd4; tick();

        // Same-edge write/read bypass
        ld[0] = 1'b1; wa[0] = 4'd7; wd[0] = 32'h11; raa[0] = 4'd0; tick();
        ld[0] = 1'b1; wa[0] = 4'd7; wd[0] = 32'h3C; raa[0] = 4'd7; rab[0] = 4'd6; tick();
        ld[0] = 1'b0; raa[0] = 4'd7; rab[0] = 4'd7; tick();

        // Fill, then soft clear with a write that coincides with the request
        for (int i = 0; i < 16; i++) begin
            ld[0] = 1'b1; wa[0] = 4'(i); wd[0] = 32'($urandom_range(1, 255));
            tick();
        end
        clr[0] = 1'b1; ld[0] = 1'b1; wa[0] = 4'd9; wd[0] = 32'h5A; raa[0] = 4'd9; tick();
        clr[0] = 1'b0;
        for (int s = 1; s <= 16; s++) begin
            ld[0]  = (s == 5);
            wa[0]  = 4'd9;
            wd[0]  = 32'hAA;
            raa[0] = 4'd9;
            tick();
        end
        ld[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raa[0] = 4'(i);
            rab[0] = 4'(i);
            tick();
        end

        // ClrReq held during the sweep must not restart it
        clr[0] = 1'b1;
        for (int s = 0; s < 10; s++) tick();
        clr[0] = 1'b0;
        for (int s = 0; s < 10; s++) tick();

        // Reset mid-sweep restarts it from entry 0
        ld[0] = 1'b1; wa[0] = 4'd1; wd[0] = 32'h42; tick();
        ld[0] = 1'b0; clr[0] = 1'b1; tick();
        clr[0] = 1'b0;
        for (int s = 1; s <= 8; s++) tick();
        clb[0] = 1'b0; ld[0] = 1'b1; clr[0] = 1'b1; tick();
        idle(0);
        for (int s = 0; s < 18; s++) begin
            raa[0] = 4'($urandom_range(0, 15));
            tick();
        end

        // Randomised traffic on both instances
        for (int n = 0; n < 1500; n++) begin
            rand_in(0);
            rand_in(1);
            tick();
        end

        @(posedge clk);
        #3;
        cmp(0, "queue_drained", 32'(q0.size()), 32'd0);
        cmp(1, "queue_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
